// File: rtl/writeback_queue.sv
// writeback_queue: in-order FIFO of pending register writes feeding a
// registered register-file write port. Supports store-to-load style
// forwarding of the newest pending value for a probed register index.
module writeback_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       Reset,
  input  logic                       wb_valid,
  input  logic [2:0]                 wb_address,
  input  logic [15:0]                wb_data,
  output logic                       wb_ready,
  input  logic                       Hold,
  output logic                       Reg_Write,
  output logic [2:0]                 Reg_input_address,
  output logic [15:0]                Reg_input_data,
  input  logic [2:0]                 lookup_address,
  output logic                       lookup_hit,
  output logic [15:0]                lookup_data,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [2:0]    r_mem_addr [DEPTH];
  logic [15:0]   r_mem_data [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_wr;
  logic [2:0]    r_wr_addr;
  logic [15:0]   r_wr_data;

  logic          w_enq;
  logic          w_drn;
  logic          w_hit;
  logic [15:0]   w_hit_data;

  // Ready depends only on occupancy; a same-cycle drain does not open a slot.
  assign wb_ready = (r_count < CW'(DEPTH));
  assign w_enq    = wb_valid && wb_ready;
  assign w_drn    = (r_count != '0) && !Hold;

  // Entry storage: written at the tail on enqueue, never cleared.
  always_ff @(posedge CLK) begin
    if (w_enq && !Reset) begin
      r_mem_addr[r_tail] <= wb_address;
      r_mem_data[r_tail] <= wb_data;
    end
  end

  // Pointers and occupancy; reset discards anything pending.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_tail <= r_tail + AW'(1);
      if (w_drn) r_head <= r_head + AW'(1);
      case ({w_enq, w_drn})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Output register: strobe for one cycle per drained entry, hold address/data otherwise.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_wr      <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else if (w_drn) begin
      r_wr      <= 1'b1;
      r_wr_addr <= r_mem_addr[r_head];
      r_wr_data <= r_mem_data[r_head];
    end else begin
      r_wr      <= 1'b0;
    end
  end

  // Forwarding: output register is the oldest candidate, then FIFO oldest to
  // newest, so the last match (newest write) wins. The wb_* offer is not seen.
  always_comb begin
    w_hit      = r_wr && (r_wr_addr == lookup_address);
    w_hit_data = w_hit ? r_wr_data : 16'h0000;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < r_count) &&
          (r_mem_addr[r_head + AW'(i)] == lookup_address)) begin
        w_hit      = 1'b1;
        w_hit_data = r_mem_data[r_head + AW'(i)];
      end
    end
  end

  assign lookup_hit        = w_hit;
  assign lookup_data       = w_hit_data;
  assign Reg_Write         = r_wr;
  assign Reg_input_address = r_wr_addr;
  assign Reg_input_data    = r_wr_data;
  assign count             = r_count;
endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue: each task drives one scenario and
// checks outputs 1ns after the rising edge against hand-computed values.
module tb_writeback_queue;
  logic        CLK = 1'b0;
  logic        Reset;
  logic        wb_valid;
  logic [2:0]  wb_address;
  logic [15:0] wb_data;
  logic        wb_ready;
  logic        Hold;
  logic        Reg_Write;
  logic [2:0]  Reg_input_address;
  logic [15:0] Reg_input_data;
  logic [2:0]  lookup_address;
  logic        lookup_hit;
  logic [15:0] lookup_data;
  logic [2:0]  count;

  int n_tests = 0;
  int n_fail  = 0;

  writeback_queue #(.DEPTH(4)) dut (
    .CLK(CLK), .Reset(Reset),
    .wb_valid(wb_valid), .wb_address(wb_address), .wb_data(wb_data),
    .wb_ready(wb_ready), .Hold(Hold),
    .Reg_Write(Reg_Write), .Reg_input_address(Reg_input_address),
    .Reg_input_data(Reg_input_data),
    .lookup_address(lookup_address), .lookup_hit(lookup_hit),
    .lookup_data(lookup_data), .count(count)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; wb_valid = 1'b1; wb_address = 3'd2; wb_data = 16'hDEAD;
    Hold = 1'b0; lookup_address = 3'd2;
    tick();
    n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
    n_tests++; if (Reg_Write !== 1'b0) begin n_fail++; $display("FAIL reset_wr got %b exp 0", Reg_Write); end
    n_tests++; if (Reg_input_address !== 3'd0 || Reg_input_data !== 16'h0000) begin n_fail++;
      $display("FAIL reset_regout got %0d/%h exp 0/0000", Reg_input_address, Reg_input_data); end
    n_tests++; if (wb_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", wb_ready); end
    n_tests++; if (lookup_hit !== 1'b0 || lookup_data !== 16'h0000) begin n_fail++;
      $display("FAIL reset_lookup got %b/%h exp 0/0000", lookup_hit, lookup_data); end
    tick();
    n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_hold_count got %0d exp 0", count); end
    Reset = 1'b0; wb_valid = 1'b0;
    tick();
    n_tests++; if (Reg_Write !== 1'b0 || count !== 3'd0) begin n_fail++;
      $display("FAIL reset_release got wr=%b cnt=%0d exp 0/0", Reg_Write, count); end
  endtask

  task automatic test_single();
    wb_valid = 1'b1; wb_address = 3'd3; wb_data = 16'h1234; lookup_address = 3'd3;
    tick();
    wb_valid = 1'b0;
    n_tests++; if (count !== 3'd1 || Reg_Write !== 1'b0) begin n_fail++;
      $display("FAIL single_e1 got cnt=%0d wr=%b exp 1/0", count, Reg_Write); end
    n_tests++; if (lookup_hit !== 1'b1 || lookup_data !== 16'h1234) begin n_fail++;
      $display("FAIL single_fwd_fifo got %b/%h exp 1/1234", lookup_hit, lookup_data); end
    tick();
    n_tests++; if (Reg_Write !== 1'b1 || Reg_input_address !== 3'd3 || Reg_input_data !== 16'h1234) begin n_fail++;
      $display("FAIL single_e2 got %b/%0d/%h exp 1/3/1234", Reg_Write, Reg_input_address, Reg_input_data); end
    n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL single_cnt got %0d exp 0", count); end
    n_tests++; if (lookup_hit !== 1'b1 || lookup_data !== 16'h1234) begin n_fail++;
      $display("FAIL single_fwd_out got %b/%h exp 1/1234", lookup_hit, lookup_data); end
    tick();
    n_tests++; if (Reg_Write !== 1'b0 || Reg_input_address !== 3'd3 || Reg_input_data !== 16'h1234) begin n_fail++;
      $display("FAIL single_e3 got %b/%0d/%h exp 0/3/1234", Reg_Write, Reg_input_address, Reg_input_data); end
    n_tests++; if (lookup_hit !== 1'b0 || lookup_data !== 16'h0000) begin n_fail++;
      $display("FAIL single_nohit got %b/%h exp 0/0000", lookup_hit, lookup_data); end
  endtask

  task automatic test_fill();
    logic [2:0]  exp_a [5];
    logic [15:0] exp_d [5];
    exp_a[0] = 3'd1; exp_a[1] = 3'd2; exp_a[2] = 3'd3; exp_a[3] = 3'd4; exp_a[4] = 3'd6;
    exp_d[0] = 16'hA001; exp_d[1] = 16'hA002; exp_d[2] = 16'hA003; exp_d[3] = 16'hA004; exp_d[4] = 16'hA005;
    Hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wb_valid = 1'b1; wb_address = exp_a[i]; wb_data = exp_d[i];
      tick();
      n_tests++; if (Reg_Write !== 1'b0) begin n_fail++; $display("FAIL fill_hold_wr[%0d] got %b exp 0", i, Reg_Write); end
    end
    n_tests++; if (count !== 3'd4 || wb_ready !== 1'b0) begin n_fail++;
      $display("FAIL fill_full got cnt=%0d rdy=%b exp 4/0", count, wb_ready); end
    wb_address = exp_a[4]; wb_data = exp_d[4]; lookup_address = 3'd6;
    #1;
    n_tests++; if (lookup_hit !== 1'b0) begin n_fail++; $display("FAIL fill_offer_excluded got %b exp 0", lookup_hit); end
    tick();
    n_tests++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_5th_rejected got %0d exp 4", count); end
    Hold = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 1) wb_valid = 1'b0;
      n_tests++; if (Reg_Write !== 1'b1 || Reg_input_address !== exp_a[i] || Reg_input_data !== exp_d[i]) begin n_fail++;
        $display("FAIL fill_drain[%0d] got %b/%0d/%h exp 1/%0d/%h", i, Reg_Write, Reg_input_address, Reg_input_data, exp_a[i], exp_d[i]); end
      if (i < 2) begin
        n_tests++; if (count !== 3'd3) begin n_fail++; $display("FAIL fill_cnt[%0d] got %0d exp 3", i, count); end
      end
    end
    tick();
    n_tests++; if (Reg_Write !== 1'b0 || count !== 3'd0) begin n_fail++;
      $display("FAIL fill_done got wr=%b cnt=%0d exp 0/0", Reg_Write, count); end
  endtask

  task automatic test_back_to_back();
    Hold = 1'b0;
    for (int k = 0; k < 10; k++) begin
      wb_valid = 1'b1; wb_address = 3'(k % 8); wb_data = 16'hB000 + 16'(k);
      tick();
      n_tests++; if (count > 3'd1) begin n_fail++; $display("FAIL b2b_cnt[%0d] got %0d exp <=1", k, count); end
      if (k == 0) begin
        n_tests++; if (Reg_Write !== 1'b0) begin n_fail++; $display("FAIL b2b_first got %b exp 0", Reg_Write); end
      end else begin
        n_tests++; if (Reg_Write !== 1'b1 || Reg_input_address !== 3'((k - 1) % 8) || Reg_input_data !== 16'hB000 + 16'(k - 1)) begin n_fail++;
          $display("FAIL b2b_out[%0d] got %b/%0d/%h exp 1/%0d/%h", k - 1, Reg_Write, Reg_input_address, Reg_input_data, (k - 1) % 8, 16'hB000 + 16'(k - 1)); end
      end
    end
    wb_valid = 1'b0;
    tick();
    n_tests++; if (Reg_Write !== 1'b1 || Reg_input_address !== 3'd1 || Reg_input_data !== 16'hB009) begin n_fail++;
      $display("FAIL b2b_last got %b/%0d/%h exp 1/1/b009", Reg_Write, Reg_input_address, Reg_input_data); end
    n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL b2b_cnt_end got %0d exp 0", count); end
    tick();
    n_tests++; if (Reg_Write !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got %b exp 0", Reg_Write); end
  endtask

  task automatic test_forward();
    Hold = 1'b1;
    wb_valid = 1'b1; wb_address = 3'd5; wb_data = 16'h1111; tick();
    wb_address = 3'd5; wb_data = 16'h2222; tick();
    wb_address = 3'd0; wb_data = 16'h0000; tick();
    wb_address = 3'd6; wb_data = 16'h3333;
    lookup_address = 3'd5; #1;
    n_tests++; if (lookup_hit !== 1'b1 || lookup_data !== 16'h2222) begin n_fail++;
      $display("FAIL fwd_newest got %b/%h exp 1/2222", lookup_hit, lookup_data); end
    lookup_address = 3'd6; #1;
    n_tests++; if (lookup_hit !== 1'b0 || lookup_data !== 16'h0000) begin n_fail++;
      $display("FAIL fwd_miss got %b/%h exp 0/0000", lookup_hit, lookup_data); end
    lookup_address = 3'd0; #1;
    n_tests++; if (lookup_hit !== 1'b1 || lookup_data !== 16'h0000) begin n_fail++;
      $display("FAIL fwd_reg0 got %b/%h exp 1/0000", lookup_hit, lookup_data); end
    wb_valid = 1'b0; Hold = 1'b0; lookup_address = 3'd5;
    tick();
    n_tests++; if (Reg_input_data !== 16'h1111 || lookup_hit !== 1'b1 || lookup_data !== 16'h2222) begin n_fail++;
      $display("FAIL fwd_drain1 got out=%h fwd=%b/%h exp 1111 1/2222", Reg_input_data, lookup_hit, lookup_data); end
    tick();
    n_tests++; if (Reg_input_data !== 16'h2222 || lookup_hit !== 1'b1 || lookup_data !== 16'h2222) begin n_fail++;
      $display("FAIL fwd_drain2 got out=%h fwd=%b/%h exp 2222 1/2222", Reg_input_data, lookup_hit, lookup_data); end
    tick();
    n_tests++; if (Reg_Write !== 1'b1 || Reg_input_address !== 3'd0 || lookup_hit !== 1'b0) begin n_fail++;
      $display("FAIL fwd_drain3 got wr=%b a=%0d hit=%b exp 1/0/0", Reg_Write, Reg_input_address, lookup_hit); end
    tick();
    n_tests++; if (Reg_Write !== 1'b0 || count !== 3'd0) begin n_fail++;
      $display("FAIL fwd_done got wr=%b cnt=%0d exp 0/0", Reg_Write, count); end
  endtask

  task automatic test_reset_mid();
    Hold = 1'b1; lookup_address = 3'd7;
    for (int i = 0; i < 3; i++) begin
      wb_valid = 1'b1; wb_address = 3'd7; wb_data = 16'hC001 + 16'(i);
      tick();
    end
    n_tests++; if (count !== 3'd3 || lookup_data !== 16'hC003) begin n_fail++;
      $display("FAIL rmid_pending got cnt=%0d fwd=%h exp 3/c003", count, lookup_data); end
    Reset = 1'b1;
    tick();
    n_tests++; if (count !== 3'd0 || Reg_Write !== 1'b0 || wb_ready !== 1'b1) begin n_fail++;
      $display("FAIL rmid_reset got cnt=%0d wr=%b rdy=%b exp 0/0/1", count, Reg_Write, wb_ready); end
    n_tests++; if (lookup_hit !== 1'b0 || lookup_data !== 16'h0000) begin n_fail++;
      $display("FAIL rmid_lookup got %b/%h exp 0/0000", lookup_hit, lookup_data); end
    Reset = 1'b0; wb_valid = 1'b0; Hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++; if (Reg_Write !== 1'b0 || count !== 3'd0) begin n_fail++;
        $display("FAIL rmid_discard[%0d] got wr=%b cnt=%0d exp 0/0", i, Reg_Write, count); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_forward();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 Parameter: DEPTH, default 4, number of pending-write FIFO entries; power of two, minimum 2.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset, sampled on rising edge of CLK.
REQ-004 wb_valid  input  1  producer has a register write to enqueue.
REQ-005 wb_address  input  3  destination register index for the offered write.
REQ-006 wb_data  input  16  data for the offered write.
REQ-007 wb_ready  output  1  queue can accept; high when count < DEPTH.
REQ-008 Hold  input  1  register file write port unavailable; suspends draining.
REQ-009 Reg_Write  output  1  registered write strobe to register file.
REQ-010 Reg_input_address  output  3  registered write address to register file.
REQ-011 Reg_input_data  output  16  registered write data to register file.
REQ-012 lookup_address  input  3  register index probed for pending writes.
REQ-013 lookup_hit  output  1  combinational; a pending write to lookup_address exists.
REQ-014 lookup_data  output  16  combinational; data of newest pending write to lookup_address, 0 when no hit.
REQ-015 count  output  log2(DEPTH)+1  number of entries held in FIFO, excluding output register.

Function
REQ-016 Enqueue occurs on a rising edge when wb_valid && wb_ready; the entry is written at the tail and the tail pointer advances modulo DEPTH.
REQ-017 wb_ready is computed from the current count only; there is no pass-through when full, even if a drain occurs in the same cycle.
REQ-018 Drain occurs on a rising edge when count > 0 && !Hold: the head entry loads Reg_input_address/Reg_input_data, Reg_Write is set to 1, and the head pointer advances modulo DEPTH.
REQ-019 On any edge without a drain, Reg_Write is set to 0, and Reg_input_address/Reg_input_data hold their previous values.
REQ-020 Simultaneous enqueue and drain leaves count unchanged; enqueue only increments count; drain only decrements count.
REQ-021 Latency: a write accepted at edge N into an empty queue with Hold low presents Reg_Write=1 after edge N+1, for exactly one cycle.
REQ-022 Writes drain in acceptance order; there is no coalescing of same-address entries, and no reordering.
REQ-023 Hold asserted freezes the FIFO contents and pointers, except for enqueues; Reg_Write is 0 throughout Hold.
REQ-024 Lookup scans FIFO entries from newest to oldest, then the output register when Reg_Write=1; the first address match supplies lookup_data.
REQ-025 Lookup excludes the entry being offered on wb_* in the current cycle.
REQ-026 Register index 0 is an ordinary register: no special-casing on enqueue, drain or lookup.

Reset
REQ-027 Reset high at a rising edge clears head, tail and count to 0, sets Reg_Write to 0, and sets Reg_input_address to 0 and Reg_input_data to 0x0000.
REQ-028 Reset has priority over simultaneous enqueue and drain; entries pending at reset are discarded and never written.
REQ-029 While Reset is high: wb_ready=1, lookup_hit=0 and lookup_data=0x0000 from the first edge after Reset is sampled.

Verification
REQ-030 Single write: empty queue, Hold=0, enqueue (addr 3, 0x1234) at edge 1 -> Reg_Write=1, address=3, data=0x1234 after edge 2; Reg_Write=0 after edge 3; count returns to 0.
REQ-031 Fill/full: Hold=1, enqueue 4 writes (addr 1..4, 0xA001..0xA004) -> count=4, wb_ready=0; a 5th offer is not accepted; release Hold -> writes emerge on 4 consecutive cycles, in order 1..4; the 5th is accepted the cycle after wb_ready rises.
REQ-032 Wrap-around and simultaneous events: stream 10 back-to-back writes with Hold=0 -> count stays at or below 1, pointers wrap, all 10 appear in order with one-cycle spacing.
REQ-033 Forwarding: Hold=1, enqueue (addr 5, 0x1111) then (addr 5, 0x2222); lookup_address=5 -> lookup_hit=1, lookup_data=0x2222; lookup_address=6 -> lookup_hit=0, lookup_data=0x0000.
REQ-034 Reset mid-operation: 3 entries pending with Hold=1; assert Reset for one edge with wb_valid=1 -> count=0 and Reg_Write=0 after that edge; no pending write ever reaches Reg_Write after Hold is released.
